// File: rtl/proc_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, ALU encodings,
// FSM states and the decoded control word.
package proc_pkg;

    localparam int PROC_PC_W   = 5;
    localparam int PROC_DATA_W = 8;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_ST   = 4'h2;
    localparam logic [3:0] OP_MOVA = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_MOVR = 4'h9;
    localparam logic [3:0] OP_LDI  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_RSVD_D = 4'hD;
    localparam logic [3:0] OP_RSVD_E = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5
    } alu_op_t;

    typedef enum logic [2:0] {
        S_FETCH      = 3'd0,
        S_DECODE     = 3'd1,
        S_OPND_FETCH = 3'd2,
        S_OPND       = 3'd3,
        S_EXEC       = 3'd4,
        S_HALT       = 3'd5
    } state_t;

    typedef struct packed {
        logic    load_en;
        logic    store_en;
        logic    r0_ce;
        logic    r1_ce;
        logic    r0_oe;
        logic    r1_oe;
        logic    acu_ce;
        logic    acu_oe;
        alu_op_t alu_op;
        logic    imm_oe;
        logic    illegal;
    } ctrl_t;

    function automatic logic is_two_byte(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_JMP) || (op == OP_JZ);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder: turns {opcode, register select} into the
// control word the sequencer registers during EXEC.
module instr_decoder
    import proc_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       sel_r1,
    output ctrl_t      ctrl
);

    // Map each opcode onto its set of datapath strobes; unlisted opcodes drive nothing.
    always_comb begin
        ctrl = '0;
        case (opcode)
            OP_LD: begin
                ctrl.load_en = 1'b1;
                ctrl.r0_ce   = ~sel_r1;
                ctrl.r1_ce   = sel_r1;
            end
            OP_ST: begin
                ctrl.store_en = 1'b1;
                ctrl.r0_oe    = ~sel_r1;
                ctrl.r1_oe    = sel_r1;
            end
            OP_MOVA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                ctrl.r0_oe  = ~sel_r1;
                ctrl.r1_oe  = sel_r1;
                ctrl.acu_ce = 1'b1;
                case (opcode)
                    OP_ADD:  ctrl.alu_op = ALU_ADD;
                    OP_SUB:  ctrl.alu_op = ALU_SUB;
                    OP_AND:  ctrl.alu_op = ALU_AND;
                    OP_OR:   ctrl.alu_op = ALU_OR;
                    OP_XOR:  ctrl.alu_op = ALU_XOR;
                    default: ctrl.alu_op = ALU_PASS;
                endcase
            end
            OP_MOVR: begin
                ctrl.acu_oe = 1'b1;
                ctrl.r0_ce  = ~sel_r1;
                ctrl.r1_ce  = sel_r1;
            end
            OP_LDI: begin
                ctrl.imm_oe = 1'b1;
                ctrl.r0_ce  = ~sel_r1;
                ctrl.r1_ce  = sel_r1;
            end
            OP_RSVD_D, OP_RSVD_E: begin
                ctrl.illegal = 1'b1;
            end
            OP_NOP, OP_JMP, OP_JZ, OP_HALT: begin
                ctrl = '0;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute controller: walks program memory, latches instruction
// and operand bytes, and fires one-cycle datapath strobes in EXEC.
module instr_sequencer
    import proc_pkg::*;
#(
    parameter int PC_W   = PROC_PC_W,
    parameter int DATA_W = PROC_DATA_W
) (
    input  logic              clk,
    input  logic              rstn_ext,
    input  logic [DATA_W-1:0] prog_mem_data,
    input  logic              zero_flag,
    output logic [PC_W-1:0]   prog_cnt,
    output logic [3:0]        instr_code,
    output logic              load_en,
    output logic              store_en,
    output logic              R0_ce,
    output logic              R1_ce,
    output logic              R0_oe,
    output logic              R1_oe,
    output logic              acu_ce,
    output logic              acu_oe,
    output logic [2:0]        alu_op,
    output logic              imm_oe,
    output logic [DATA_W-1:0] imm_data,
    output logic              halted,
    output logic              illegal_op
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_t            state;
    logic [3:0]        ir_op;
    logic              ir_n;
    logic [DATA_W-1:0] operand;
    ctrl_t             ctrl_q;
    ctrl_t             dec_ctrl;
    logic [3:0]        dec_op;
    logic              dec_n;
    logic              take_jump;

    // A one-byte instruction is decoded straight off the ROM bus in DECODE so its
    // strobes land exactly in EXEC; two-byte ones decode from the latched IR.
    assign dec_op = (state == S_DECODE) ? prog_mem_data[7:4] : ir_op;
    assign dec_n  = (state == S_DECODE) ? prog_mem_data[0]   : ir_n;

    instr_decoder u_decoder (
        .opcode (dec_op),
        .sel_r1 (dec_n),
        .ctrl   (dec_ctrl)
    );

    // Jump targets come from the operand byte; JZ looks at zero_flag during EXEC.
    assign take_jump = (ir_op == OP_JMP) || ((ir_op == OP_JZ) && zero_flag);

    // Sequencer FSM: owns the PC, IR, operand, halted flag and the registered strobe word.
    always_ff @(posedge clk or negedge rstn_ext) begin
        if (!rstn_ext) begin
            state    <= S_FETCH;
            prog_cnt <= '0;
            ir_op    <= '0;
            ir_n     <= 1'b0;
            operand  <= '0;
            ctrl_q   <= '0;
            halted   <= 1'b0;
        end else begin
            ctrl_q <= '0;
            case (state)
                S_FETCH: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    ir_op <= prog_mem_data[7:4];
                    ir_n  <= prog_mem_data[0];
                    if (prog_mem_data[7:4] == OP_HALT) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end else if (is_two_byte(prog_mem_data[7:4])) begin
                        prog_cnt <= prog_cnt + PC_ONE;
                        state    <= S_OPND_FETCH;
                    end else begin
                        ctrl_q <= dec_ctrl;
                        state  <= S_EXEC;
                    end
                end
                S_OPND_FETCH: begin
                    state <= S_OPND;
                end
                S_OPND: begin
                    operand <= prog_mem_data;
                    ctrl_q  <= dec_ctrl;
                    state   <= S_EXEC;
                end
                S_EXEC: begin
                    prog_cnt <= take_jump ? operand[PC_W-1:0] : prog_cnt + PC_ONE;
                    state    <= S_FETCH;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    assign instr_code = ir_op;
    assign imm_data   = operand;
    assign load_en    = ctrl_q.load_en;
    assign store_en   = ctrl_q.store_en;
    assign R0_ce      = ctrl_q.r0_ce;
    assign R1_ce      = ctrl_q.r1_ce;
    assign R0_oe      = ctrl_q.r0_oe;
    assign R1_oe      = ctrl_q.r1_oe;
    assign acu_ce     = ctrl_q.acu_ce;
    assign acu_oe     = ctrl_q.acu_oe;
    assign alu_op     = ctrl_q.alu_op;
    assign imm_oe     = ctrl_q.imm_oe;
    assign illegal_op = ctrl_q.illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: an instruction-level program model
// predicts strobe, PC and halt events; a negedge monitor matches DUT activity.
module tb_instr_sequencer;

    typedef struct {
        int          cyc;
        logic [12:0] vec;
        logic [7:0]  imm;
    } ctrl_ev_t;

    typedef struct {
        int cyc;
        int pc;
    } pc_ev_t;

    logic        clk;
    logic        rstn_ext;
    logic [7:0]  prog_mem_data;
    logic        zero_flag;
    logic [4:0]  prog_cnt;
    logic [3:0]  instr_code;
    logic        load_en, store_en, R0_ce, R1_ce, R0_oe, R1_oe;
    logic        acu_ce, acu_oe, imm_oe, halted, illegal_op;
    logic [2:0]  alu_op;
    logic [7:0]  imm_data;

    logic [7:0]  rom [32];
    logic [12:0] ctrl_vec;
    logic [30:0] all_out;
    logic [7:0]  rnd_byte;

    int          cyc;
    int          total;
    int          bad;
    bit          mon_on;
    string       test_name;
    logic [4:0]  last_pc;
    logic        last_halted;
    ctrl_ev_t    mon_cev;
    pc_ev_t      mon_pev;
    int          mon_hcyc;

    ctrl_ev_t    exp_ctrl_q [$];
    pc_ev_t      exp_pc_q [$];
    int          exp_halt_q [$];

    instr_sequencer dut (
        .clk           (clk),
        .rstn_ext      (rstn_ext),
        .prog_mem_data (prog_mem_data),
        .zero_flag     (zero_flag),
        .prog_cnt      (prog_cnt),
        .instr_code    (instr_code),
        .load_en       (load_en),
        .store_en      (store_en),
        .R0_ce         (R0_ce),
        .R1_ce         (R1_ce),
        .R0_oe         (R0_oe),
        .R1_oe         (R1_oe),
        .acu_ce        (acu_ce),
        .acu_oe        (acu_oe),
        .alu_op        (alu_op),
        .imm_oe        (imm_oe),
        .imm_data      (imm_data),
        .halted        (halted),
        .illegal_op    (illegal_op)
    );

    assign ctrl_vec = {load_en, store_en, R0_ce, R1_ce, R0_oe, R1_oe,
                       acu_ce, acu_oe, alu_op, imm_oe, illegal_op};
    assign all_out  = {prog_cnt, instr_code, ctrl_vec, imm_data, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program ROM: data for an address appears one cycle later.
    always @(posedge clk) prog_mem_data <= rom[prog_cnt];

    // Cycle index since reset release; cycle 0 is the first FETCH.
    always @(posedge clk or negedge rstn_ext) begin
        if (!rstn_ext) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    // Expected strobe word for one instruction, built from the opcode table.
    function automatic logic [12:0] expect_ctrl(input logic [3:0] op, input logic n);
        logic       ld  = 1'b0;
        logic       st  = 1'b0;
        logic       rce = 1'b0;
        logic       roe = 1'b0;
        logic       ace = 1'b0;
        logic       aoe = 1'b0;
        logic       io  = 1'b0;
        logic       ill = 1'b0;
        logic [2:0] alu = 3'd0;
        if (op == 4'h1) begin
            ld = 1'b1; rce = 1'b1;
        end else if (op == 4'h2) begin
            st = 1'b1; roe = 1'b1;
        end else if (op >= 4'h3 && op <= 4'h8) begin
            roe = 1'b1; ace = 1'b1; alu = 3'(op - 4'h3);
        end else if (op == 4'h9) begin
            aoe = 1'b1; rce = 1'b1;
        end else if (op == 4'hA) begin
            io = 1'b1; rce = 1'b1;
        end else if (op == 4'hD || op == 4'hE) begin
            ill = 1'b1;
        end
        return {ld, st, rce & ~n, rce & n, roe & ~n, roe & n, ace, aoe, alu, io, ill};
    endfunction

    // Run the program instruction by instruction and queue every visible event.
    task automatic build_expect(input int window);
        int          pc, t, cur, nxt, exec_t, dur;
        logic [7:0]  b, b2, imm;
        logic [3:0]  op;
        logic        two;
        logic [12:0] v;
        pc = 0; t = 0; cur = 0; imm = 8'h00; b2 = 8'h00;
        while (t < window) begin
            b  = rom[pc];
            op = b[7:4];
            if (op == 4'hF) begin
                if (t + 2 < window) exp_halt_q.push_back(t + 2);
                break;
            end
            two = (op == 4'hA) || (op == 4'hB) || (op == 4'hC);
            if (two) begin
                b2  = rom[(pc + 1) % 32];
                imm = b2;
                if (t + 2 < window) exp_pc_q.push_back('{t + 2, (pc + 1) % 32});
                cur    = (pc + 1) % 32;
                exec_t = t + 4;
                dur    = 5;
                if (op == 4'hB || (op == 4'hC && zero_flag)) nxt = int'(b2) % 32;
                else                                         nxt = (pc + 2) % 32;
            end else begin
                exec_t = t + 2;
                dur    = 3;
                nxt    = (pc + 1) % 32;
            end
            v = expect_ctrl(op, b[0]);
            if (v != 13'd0 && exec_t < window) exp_ctrl_q.push_back('{exec_t, v, imm});
            t = t + dur;
            if (t < window && nxt != cur) exp_pc_q.push_back('{t, nxt});
            cur = nxt;
            pc  = nxt;
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows strobes, a new PC or a halt.
    always @(negedge clk) begin
        if (mon_on && rstn_ext) begin
            total++;
            if ($countones({R0_oe, R1_oe, acu_oe, imm_oe}) > 1) begin
                bad++;
                $display("[TB] FAIL %s bus_contention: oe=%b at cyc=%0d, required at most one", test_name, {R0_oe, R1_oe, acu_oe, imm_oe}, cyc);
            end
            if (ctrl_vec != 13'd0) begin
                total++;
                if (exp_ctrl_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL %s ctrl_event: got vec=%b imm=%h at cyc=%0d, required no strobes", test_name, ctrl_vec, imm_data, cyc);
                end else begin
                    mon_cev = exp_ctrl_q.pop_front();
                    if (mon_cev.cyc != cyc || mon_cev.vec != ctrl_vec || mon_cev.imm != imm_data) begin
                        bad++;
                        $display("[TB] FAIL %s ctrl_event: got cyc=%0d vec=%b imm=%h, required cyc=%0d vec=%b imm=%h", test_name, cyc, ctrl_vec, imm_data, mon_cev.cyc, mon_cev.vec, mon_cev.imm);
                    end
                end
            end
            if (prog_cnt != last_pc) begin
                total++;
                if (exp_pc_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL %s pc_event: got pc=%0d at cyc=%0d, required no change", test_name, prog_cnt, cyc);
                end else begin
                    mon_pev = exp_pc_q.pop_front();
                    if (mon_pev.cyc != cyc || mon_pev.pc != int'(prog_cnt)) begin
                        bad++;
                        $display("[TB] FAIL %s pc_event: got pc=%0d cyc=%0d, required pc=%0d cyc=%0d", test_name, prog_cnt, cyc, mon_pev.pc, mon_pev.cyc);
                    end
                end
            end
            if (halted && !last_halted) begin
                total++;
                if (exp_halt_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL %s halt_event: got halt at cyc=%0d, required none", test_name, cyc);
                end else begin
                    mon_hcyc = exp_halt_q.pop_front();
                    if (mon_hcyc != cyc) begin
                        bad++;
                        $display("[TB] FAIL %s halt_event: got cyc=%0d, required cyc=%0d", test_name, cyc, mon_hcyc);
                    end
                end
            end
        end
        last_pc     = prog_cnt;
        last_halted = halted;
    end

    // Every predicted event must have been consumed by the monitor.
    task automatic check_output();
        total++;
        if (exp_ctrl_q.size() != 0 || exp_pc_q.size() != 0 || exp_halt_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s drained: got pending ctrl=%0d pc=%0d halt=%0d, required 0 0 0", test_name, exp_ctrl_q.size(), exp_pc_q.size(), exp_halt_q.size());
        end
    endtask

    // Hold reset, check the idle outputs, release and let the program run.
    task automatic apply_stimulus(input string name, input int window);
        test_name = name;
        mon_on    = 1'b0;
        rstn_ext  = 1'b0;
        exp_ctrl_q.delete();
        exp_pc_q.delete();
        exp_halt_q.delete();
        build_expect(window);
        repeat (8) @(posedge clk);
        #2;
        total++;
        if (all_out !== 31'd0) begin
            bad++;
            $display("[TB] FAIL %s reset_state: got %h, required 0", name, all_out);
        end
        @(posedge clk);
        #2;
        rstn_ext = 1'b1;
        mon_on   = 1'b1;
        repeat (window) @(posedge clk);
        #2;
        mon_on = 1'b0;
        check_output();
    endtask

    task automatic clear_rom(input logic [7:0] fill);
        for (int i = 0; i < 32; i++) rom[i] = fill;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        mon_on      = 1'b0;
        rstn_ext    = 1'b0;
        zero_flag   = 1'b0;
        last_pc     = '0;
        last_halted = 1'b0;
        test_name   = "init";
        clear_rom(8'h00);

        apply_stimulus("nop_wrap", 105);

        clear_rom(8'h00);
        rom[0] = 8'h10; rom[1] = 8'h41; rom[2] = 8'hF0;
        apply_stimulus("ld_add_halt", 20);
        total++;
        if (halted !== 1'b1 || prog_cnt !== 5'd2 || instr_code !== 4'hF) begin
            bad++;
            $display("[TB] FAIL halt_hold: got halted=%b pc=%0d code=%h, required 1 2 f", halted, prog_cnt, instr_code);
        end

        clear_rom(8'h00);
        rom[0] = 8'hA1; rom[1] = 8'h5A;
        apply_stimulus("ldi", 12);

        clear_rom(8'h00);
        rom[0] = 8'hC0; rom[1] = 8'h07;
        zero_flag = 1'b1;
        apply_stimulus("jz_taken", 12);
        zero_flag = 1'b0;
        apply_stimulus("jz_not_taken", 12);

        clear_rom(8'h00);
        rom[0] = 8'hB0; rom[1] = 8'h1E; rom[30] = 8'hB0; rom[31] = 8'hFF;
        apply_stimulus("jmp_upper_bits", 20);

        clear_rom(8'h00);
        rom[0] = 8'h33; rom[1] = 8'hB0; rom[2] = 8'h1F; rom[31] = 8'hA0;
        apply_stimulus("ldi_wrap", 40);

        clear_rom(8'h00);
        rom[0] = 8'hB0; rom[1] = 8'h15;
        test_name = "async_reset";
        rstn_ext  = 1'b0;
        exp_ctrl_q.delete();
        exp_pc_q.delete();
        exp_halt_q.delete();
        build_expect(4);
        repeat (8) @(posedge clk);
        #2;
        rstn_ext = 1'b1;
        mon_on   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        mon_on   = 1'b0;
        rstn_ext = 1'b0;
        #1;
        total++;
        if (all_out !== 31'd0) begin
            bad++;
            $display("[TB] FAIL async_reset: got %h, required 0", all_out);
        end
        check_output();

        clear_rom(8'h00);
        rom[0] = 8'hD0;
        apply_stimulus("illegal", 12);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) begin
                rnd_byte = 8'($urandom);
                if (rnd_byte[7:4] == 4'hF && $urandom_range(0, 3) != 0)
                    rnd_byte[7:4] = 4'($urandom_range(0, 14));
                rom[i] = rnd_byte;
            end
            zero_flag = 1'($urandom_range(0, 1));
            apply_stimulus($sformatf("random_%0d", r), 150);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
